// File: rtl/delta_encoder_mc.sv
// delta_encoder_mc: multi-channel delta-modulation spike encoder
// Per-channel reference + refractory counter, valid/ready in and out
module delta_encoder_mc #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int REFRACT  = 2,
  parameter int RCNT_W   = 2,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] threshold,
  input  logic             off_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_chan,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_chan,
  output logic [1:0]       out_spike
);

  localparam int DW = WIDTH + 2;
  localparam logic [WIDTH-1:0] MAX_V = '1;
  localparam logic [CH_W:0] N_CH = (CH_W+1)'(CHANNELS);
  localparam logic [RCNT_W-1:0] R_LOAD = RCNT_W'(REFRACT);
  localparam logic signed [DW-1:0] ONE = DW'(1);
  localparam logic signed [DW-1:0] MAX_S = {2'b00, MAX_V};

  logic [WIDTH-1:0]  ref_q  [CHANNELS];
  logic [RCNT_W-1:0] rcnt_q [CHANNELS];

  logic              accept;
  logic              chan_ok;
  logic              rcnt_busy;
  logic              on_hit;
  logic              off_hit;
  logic              fire;
  logic              fire_off;
  logic [WIDTH-1:0]  cur_ref;
  logic [WIDTH-1:0]  new_ref;
  logic [RCNT_W-1:0] cur_rcnt;
  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] thr_s;
  logic signed [DW-1:0] step_s;
  logic signed [DW-1:0] up_s;
  logic signed [DW-1:0] dn_s;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign chan_ok  = {1'b0, in_chan} < N_CH;

  // pick the addressed channel's reference and refractory count
  always_comb begin
    cur_ref  = '0;
    cur_rcnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_chan == CH_W'(i)) begin
        cur_ref  = ref_q[i];
        cur_rcnt = rcnt_q[i];
      end
    end
  end

  // difference is kept two bits wider so neither it nor -t can wrap
  assign diff   = $signed({2'b00, in_data}) - $signed({2'b00, cur_ref});
  assign thr_s  = $signed({2'b00, threshold});
  assign on_hit  = diff > thr_s;
  assign off_hit = off_en && (diff < -thr_s);

  assign rcnt_busy = cur_rcnt != '0;
  assign fire      = chan_ok && !rcnt_busy && (on_hit || off_hit);
  assign fire_off  = fire && !on_hit;

  assign step_s = thr_s + ONE;
  assign up_s   = $signed({2'b00, cur_ref}) + step_s;
  assign dn_s   = $signed({2'b00, cur_ref}) - step_s;

  // reference value written when the channel fires
  always_comb begin
    new_ref = in_data;
    if (MODE != 0) begin
      if (on_hit) begin
        new_ref = (up_s > MAX_S) ? MAX_V : up_s[WIDTH-1:0];
      end else begin
        new_ref = dn_s[DW-1] ? '0 : dn_s[WIDTH-1:0];
      end
    end
  end

  // per-channel state: refractory countdown or fire-and-reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ref_q[i]  <= '0;
        rcnt_q[i] <= '0;
      end
    end else if (accept && chan_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_chan == CH_W'(i)) begin
          if (rcnt_busy) begin
            rcnt_q[i] <= cur_rcnt - 1'b1;
          end else if (fire) begin
            rcnt_q[i] <= R_LOAD;
            ref_q[i]  <= new_ref;
          end
        end
      end
    end
  end

  // result beat: load on accept, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_spike <= 2'b00;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_chan  <= in_chan;
      out_spike <= {fire_off, fire};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
